wimax_block_checker: RTL and testbench
======================================

WIMAX_BLOCK_CHECKER -- requirements
Module: wimax_block_checker

Interface
REQ-001 The block SHALL have parameter BLOCK_LEN, default 192, giving the number of serial bits per checked block (legal range 2..1024).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the per-block mismatch counter.
REQ-003 The block SHALL have parameter STAT_W, default 16, giving the width of the running block statistics counters.
REQ-004 clk  input  1  The single clock; all logic is on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 start  input  1  Start a run: clear the statistics and arm the checker.
REQ-007 stop  input  1  Return to IDLE once the current block has completed.
REQ-008 valid_in  input  1  data_in is valid this cycle.
REQ-009 data_in  input  1  Serial bit under test.
REQ-010 expected  input  BLOCK_LEN  Golden block; bit BLOCK_LEN-1 is the first bit transmitted.
REQ-011 ready_out  output  1  The checker accepts data_in this cycle.
REQ-012 block_done  output  1  One-cycle pulse marking the end of a block.
REQ-013 block_pass  output  1  The last completed block had zero mismatches.
REQ-014 err_count  output  ERR_W  Mismatch count of the last completed block.
REQ-015 blocks_checked  output  STAT_W  Number of blocks completed since start.
REQ-016 blocks_failed  output  STAT_W  Number of completed blocks with at least one mismatch.
REQ-017 first_err_idx  output  clog2(BLOCK_LEN)  Bit index of the first mismatch in the last completed block.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN and REPORT.
REQ-019 IDLE: ready_out=0; start moves to LOAD.
REQ-020 LOAD (1 cycle): ready_out=0, latch expected into an internal shadow register, set bit index to BLOCK_LEN-1, clear the working mismatch count, then move to RUN.
REQ-021 RUN: ready_out=1; a bit is accepted on valid_in&&ready_out and compared with shadow[index].
REQ-022 On a mismatch the working count SHALL increment, saturating at 2^ERR_W-1 with no wrap.
REQ-023 In RUN the index SHALL decrement on each accepted bit; when the bit at index 0 is accepted, the FSM SHALL move to REPORT.
REQ-024 REPORT (1 cycle): ready_out=0, block_done=1; register err_count, block_pass and first_err_idx; blocks_checked+=1; blocks_failed+=1 if the count is nonzero.
REQ-025 blocks_checked and blocks_failed SHALL saturate at all ones.
REQ-026 From REPORT the FSM SHALL go to IDLE if stop has been seen since LOAD (sticky flag), else to LOAD.
REQ-027 stop SHALL never truncate a block.
REQ-028 Gaps in valid_in while in RUN SHALL stall the index without any error.
REQ-029 start in any state other than IDLE SHALL abort the current block without a report, clear the statistics and outputs, clear the stop flag and go to LOAD.
REQ-030 start and stop asserted in the same cycle: start wins and the stop flag is cleared.
REQ-031 Changes on expected after LOAD SHALL not affect the current block.
REQ-032 Latency: block_done SHALL assert exactly one cycle after the acceptance of the last bit.
REQ-033 The minimum block period SHALL be BLOCK_LEN+2 cycles.

Reset
REQ-034 reset SHALL asynchronously force: state=IDLE, ready_out=0, block_done=0, block_pass=0, err_count=0, blocks_checked=0, blocks_failed=0, first_err_idx=0, shadow=0, stop flag=0.
REQ-035 Reset asserted mid-block SHALL discard the block with no report.

Configuration
REQ-036 With macro FIRST_ERR_TRACK_EN defined, the block SHALL capture the index of the first mismatch within each block and present it on first_err_idx at REPORT.
REQ-037 With FIRST_ERR_TRACK_EN defined and zero mismatches, first_err_idx SHALL read 0.
REQ-038 Without FIRST_ERR_TRACK_EN, the capture logic SHALL be omitted and first_err_idx SHALL be tied to 0; all other behaviour is unchanged.

Verification
REQ-039 BLOCK_LEN=96, expected=0xA5..., stream identical to expected with valid_in held high -> block_done 97 cycles after the first accepted bit, block_pass=1, err_count=0, blocks_checked=1.
REQ-040 BLOCK_LEN=192, bits 150 and 10 inverted -> err_count=2, block_pass=0, blocks_failed=1, first_err_idx=150 (macro on) or 0 (macro off).
REQ-041 ERR_W=4, BLOCK_LEN=96, all bits inverted -> err_count=15 (saturated), blocks_failed=1.
REQ-042 valid_in toggling 1/0 every cycle -> no errors, block_done 2*BLOCK_LEN cycles after the first accepted bit.
REQ-043 stop pulsed at bit 40, then start re-asserted at bit 20 of the next block -> the first block completes and the FSM goes to IDLE; after the re-start, counters read 0 and the FSM is in LOAD.
REQ-044 reset asserted at bit 50 -> all outputs 0 immediately, state IDLE, no block_done.

Source files
------------

// File: rtl/wimax_block_checker.sv
// WiMAX serial block checker.
// Compares a serial bit stream against a golden block latched at the start of
// each block, counts mismatches per block and keeps running pass/fail
// statistics. Blocks run back to back until stop is seen.
// Optional feature: define FIRST_ERR_TRACK_EN to capture the bit index of the
// first mismatch in each block; without it first_err_idx is tied to zero.
module wimax_block_checker #(
    parameter int BLOCK_LEN = 192,
    parameter int ERR_W     = 8,
    parameter int STAT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         valid_in,
    input  logic                         data_in,
    input  logic [BLOCK_LEN-1:0]         expected,
    output logic                         ready_out,
    output logic                         block_done,
    output logic                         block_pass,
    output logic [ERR_W-1:0]             err_count,
    output logic [STAT_W-1:0]            blocks_checked,
    output logic [STAT_W-1:0]            blocks_failed,
    output logic [$clog2(BLOCK_LEN)-1:0] first_err_idx
);

    localparam int IDX_W = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        REPORT
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [BLOCK_LEN-1:0] shadow;
    logic [IDX_W-1:0]     index;
    logic [ERR_W-1:0]     work_count;
    logic [ERR_W-1:0]     count_next;
    logic                 stop_seen;
    logic                 accept;
    logic                 mismatch;
    logic                 last_bit;

    assign ready_out  = (state == RUN);
    assign block_done = (state == REPORT);
    assign accept     = valid_in && ready_out;
    assign mismatch   = accept && (data_in != shadow[index]);
    assign last_bit   = accept && (index == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start anywhere outside IDLE aborts into a fresh LOAD
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (last_bit) next_state = REPORT;
            REPORT:  next_state = (stop_seen || stop) ? IDLE : LOAD;
            default: next_state = IDLE;
        endcase
        if (start) begin
            next_state = LOAD;
        end
    end

    // Sticky stop flag, re-armed at each LOAD and cleared by start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_seen <= 1'b0;
        end else if (start) begin
            stop_seen <= 1'b0;
        end else if (state == LOAD) begin
            stop_seen <= stop;
        end else if (stop) begin
            stop_seen <= 1'b1;
        end
    end

    // Saturating working mismatch count including the bit accepted this cycle
    always_comb begin
        count_next = work_count;
        if (mismatch && (work_count != {ERR_W{1'b1}})) begin
            count_next = work_count + 1'b1;
        end
    end

    // Golden shadow, bit index and working count for the block in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            index      <= '0;
            work_count <= '0;
        end else if (state == LOAD) begin
            shadow     <= expected;
            index      <= IDX_W'(BLOCK_LEN - 1);
            work_count <= '0;
        end else if (accept) begin
            work_count <= count_next;
            if (index != '0) begin
                index <= index - 1'b1;
            end
        end
    end

`ifdef FIRST_ERR_TRACK_EN
    logic [IDX_W-1:0] first_work;
    logic             found;
    logic [IDX_W-1:0] first_next;

    // First mismatch index of the block, including the bit accepted this cycle
    always_comb begin
        first_next = first_work;
        if (!found && mismatch) begin
            first_next = index;
        end
    end

    // Capture the first mismatch position once per block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_work <= '0;
            found      <= 1'b0;
        end else if (state == LOAD) begin
            first_work <= '0;
            found      <= 1'b0;
        end else if (mismatch && !found) begin
            first_work <= index;
            found      <= 1'b1;
        end
    end

    // Present the first mismatch index alongside the block report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_err_idx <= '0;
        end else if (start) begin
            first_err_idx <= '0;
        end else if (last_bit) begin
            first_err_idx <= first_next;
        end
    end
`else
    assign first_err_idx = '0;
`endif

    // Block results and saturating statistics, visible during REPORT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count      <= '0;
            block_pass     <= 1'b0;
            blocks_checked <= '0;
            blocks_failed  <= '0;
        end else if (start) begin
            err_count      <= '0;
            block_pass     <= 1'b0;
            blocks_checked <= '0;
            blocks_failed  <= '0;
        end else if (last_bit) begin
            err_count  <= count_next;
            block_pass <= (count_next == '0);
            if (blocks_checked != {STAT_W{1'b1}}) begin
                blocks_checked <= blocks_checked + 1'b1;
            end
            if ((count_next != '0) && (blocks_failed != {STAT_W{1'b1}})) begin
                blocks_failed <= blocks_failed + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wimax_block_checker.sv
// Self-checking bench for wimax_block_checker: table-driven blocks with a
// scoreboard of expected reports, plus stop, restart-abort and reset sequences.
module tb_wimax_block_checker;

    localparam int N  = 96;
    localparam int EW = 4;
    localparam int SW = 3;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          valid_in;
    logic          data_in;
    logic [N-1:0]  expected;
    logic          ready_out;
    logic          block_done;
    logic          block_pass;
    logic [EW-1:0] err_count;
    logic [SW-1:0] blocks_checked;
    logic [SW-1:0] blocks_failed;
    logic [IW-1:0] first_err_idx;

    wimax_block_checker #(
        .BLOCK_LEN(N),
        .ERR_W(EW),
        .STAT_W(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .valid_in(valid_in),
        .data_in(data_in),
        .expected(expected),
        .ready_out(ready_out),
        .block_done(block_done),
        .block_pass(block_pass),
        .err_count(err_count),
        .blocks_checked(blocks_checked),
        .blocks_failed(blocks_failed),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [EW-1:0] err;
        logic          pass;
        logic [IW-1:0] first;
        logic [SW-1:0] checked;
        logic [SW-1:0] failed;
    } sb_t;

    typedef struct {
        logic [N-1:0] flip;
        bit           toggle;
        int           exp_err;
        bit           exp_pass;
        int           exp_first;
    } vec_t;

    sb_t          sb_q[$];
    vec_t         vecs[8];
    int           errors = 0;
    int           checks = 0;
    int           model_checked = 0;
    int           model_failed = 0;
    logic [N-1:0] golden;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic pushExpect(input int err, input bit pass, input int first);
        sb_t e;
        if (model_checked < (2**SW) - 1) model_checked++;
        if (!pass && model_failed < (2**SW) - 1) model_failed++;
        e.err     = EW'(err);
        e.pass    = pass;
`ifdef FIRST_ERR_TRACK_EN
        e.first   = IW'(first);
`else
        e.first   = '0;
`endif
        e.checked = SW'(model_checked);
        e.failed  = SW'(model_failed);
        sb_q.push_back(e);
    endtask

    // Scoreboard: every block_done pops one expected report
    always @(negedge clk) begin
        if (reset !== 1'b1 && block_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done_queue", sb_q.size(), 1);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                checkOutput("err_count", err_count, e.err);
                checkOutput("block_pass", block_pass, e.pass);
                checkOutput("first_err_idx", first_err_idx, e.first);
                checkOutput("blocks_checked", blocks_checked, e.checked);
                checkOutput("blocks_failed", blocks_failed, e.failed);
            end
        end
    end

    // Drive one full block; expected bus is corrupted after the first bit to
    // show the shadow copy is in use
    task automatic applyStimulus(input logic [N-1:0] flip, input bit toggle, input int stop_at, input int exp_lat);
        int idx = N - 1;
        bit phase = 1'b1;
        int first_cyc = -1;
        int budget = 0;
        bit v;
        expected = golden;
        while (idx >= 0 && budget < 4 * N) begin
            @(negedge clk);
            budget++;
            v = toggle ? phase : 1'b1;
            phase = ~phase;
            valid_in = v;
            data_in = golden[idx] ^ flip[idx];
            stop = (idx == stop_at) && v && (ready_out === 1'b1);
            if (v && ready_out === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                else expected = ~golden;
                idx--;
            end
        end
        if (idx >= 0) checkOutput("stim_timeout_idx", idx, -1);
        @(negedge clk);
        valid_in = 1'b0;
        stop = 1'b0;
        data_in = 1'b0;
        checkOutput("done_after_last", block_done, 1);
        if (exp_lat > 0) checkOutput("done_latency", cyc - first_cyc + 1, exp_lat);
    endtask

    // Feed count clean bits from the top of the block, then return
    task automatic drivePartial(input int count);
        int idx = N - 1;
        int budget = 0;
        while (idx > N - 1 - count && budget < 4 * N) begin
            @(negedge clk);
            budget++;
            valid_in = 1'b1;
            data_in = golden[idx];
            if (ready_out === 1'b1) idx--;
        end
        if (budget >= 4 * N) checkOutput("partial_timeout_idx", idx, N - 1 - count);
    endtask

    initial begin
        golden = {12{8'hA5}};
        vecs[0] = '{flip: '0, toggle: 1'b0, exp_err: 0, exp_pass: 1'b1, exp_first: 0};
        vecs[1] = '{flip: (96'd1 << 70) | (96'd1 << 10), toggle: 1'b0, exp_err: 2, exp_pass: 1'b0, exp_first: 70};
        vecs[2] = '{flip: {N{1'b1}}, toggle: 1'b0, exp_err: 15, exp_pass: 1'b0, exp_first: 95};
        vecs[3] = '{flip: '0, toggle: 1'b1, exp_err: 0, exp_pass: 1'b1, exp_first: 0};
        vecs[4] = '{flip: 96'd1, toggle: 1'b1, exp_err: 1, exp_pass: 1'b0, exp_first: 0};
        vecs[5] = '{flip: 96'd1 << 95, toggle: 1'b0, exp_err: 1, exp_pass: 1'b0, exp_first: 95};
        vecs[6] = '{flip: 96'h7FFF, toggle: 1'b0, exp_err: 15, exp_pass: 1'b0, exp_first: 14};
        vecs[7] = '{flip: 96'hFFFF, toggle: 1'b0, exp_err: 15, exp_pass: 1'b0, exp_first: 15};

        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        valid_in = 1'b0;
        data_in = 1'b0;
        expected = golden;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready_out", ready_out, 0);
        checkOutput("rst_block_done", block_done, 0);
        checkOutput("rst_block_pass", block_pass, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_blocks_checked", blocks_checked, 0);
        checkOutput("rst_blocks_failed", blocks_failed, 0);
        checkOutput("rst_first_err_idx", first_err_idx, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_ready_out", ready_out, 0);

        // Back-to-back table blocks
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pushExpect(vecs[i].exp_err, vecs[i].exp_pass, vecs[i].exp_first);
            applyStimulus(vecs[i].flip, vecs[i].toggle, -1, vecs[i].toggle ? 2 * N : N + 1);
        end

        // Stop mid-block: block still completes, then the checker idles
        pushExpect(0, 1'b1, 0);
        applyStimulus('0, 1'b0, 40, N + 1);
        @(negedge clk);
        checkOutput("stop_report_to_idle", ready_out, 0);
        repeat (4) @(negedge clk);
        checkOutput("stop_stays_idle", ready_out, 0);

        // Restart from idle clears statistics
        expected = golden;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_checked = 0;
        model_failed = 0;
        checkOutput("restart_blocks_checked", blocks_checked, 0);
        checkOutput("restart_blocks_failed", blocks_failed, 0);

        // Start together with stop at bit 20 aborts without a report
        drivePartial(N - 1 - 20);
        @(negedge clk);
        valid_in = 1'b1;
        data_in = golden[20];
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        valid_in = 1'b0;
        checkOutput("abort_in_load_ready", ready_out, 0);
        checkOutput("abort_block_done", block_done, 0);
        checkOutput("abort_blocks_checked", blocks_checked, 0);
        checkOutput("abort_blocks_failed", blocks_failed, 0);
        checkOutput("abort_err_count", err_count, 0);
        checkOutput("abort_block_pass", block_pass, 0);
        pushExpect(0, 1'b1, 0);
        applyStimulus('0, 1'b0, -1, N + 1);
        repeat (2) @(negedge clk);
        checkOutput("start_clears_stop_run", ready_out, 1);

        // Reset mid-block discards the block immediately
        drivePartial(N - 1 - 50);
        @(negedge clk);
        valid_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_ready_out", ready_out, 0);
        checkOutput("midrst_block_done", block_done, 0);
        checkOutput("midrst_block_pass", block_pass, 0);
        checkOutput("midrst_blocks_checked", blocks_checked, 0);
        checkOutput("midrst_err_count", err_count, 0);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (N + 10) @(negedge clk);
        checkOutput("midrst_idle_ready", ready_out, 0);
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
